game_sequencer: RTL and testbench

Controller that sequences the 4x4 cell grid through a game. After reset it drives a burst of random scramble moves into the cells. It then hands row/column selection and `fire` to the player, counts accepted moves and freezes the board on a win. It sits between the user-input conditioning (debounce, row/column error check, fire edge detect), the random source, and the 16 cell instances. It replaces the hard-wired scramble mux in the top level.

---
 rtl/game_sequencer.sv | 177 +++++++++++++++++
 tb/tb_game_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_sequencer.sv
// Game sequencer for the 4x4 cell grid: scramble burst, settle, player moves, win freeze.
// Optional GAME_SEQUENCER_REROLL_EN re-scrambles boards that come out of the scramble already solved.
module game_sequencer #(
  parameter int SCRAMBLE_MOVES = 16,
  parameter int MOVE_GAP       = 4,
  parameter int SETTLE_CYCLES  = 4,
  parameter int COUNT_W        = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               fire_pulse,
  input  logic [3:0]         user_row_column,
  input  logic               user_nRow,
  input  logic               error,
  input  logic [2:0]         random_num,
  input  logic               win,
  output logic               fire,
  output logic [3:0]         row_column,
  output logic               x_nRow,
  output logic               scramble_state,
  output logic               game_won,
  output logic [COUNT_W-1:0] move_count
);

  localparam int GW = $clog2(MOVE_GAP + 1);
  localparam int MW = $clog2(SCRAMBLE_MOVES + 2);
  localparam int SW = $clog2(SETTLE_CYCLES + 2);

  typedef enum logic [1:0] {
    S_SCRAMBLE = 2'd0,
    S_SETTLE   = 2'd1,
    S_PLAY     = 2'd2,
    S_WIN      = 2'd3
  } state_e;

  state_e             state_q;
  logic [GW-1:0]      gap_q;
  logic [MW-1:0]      moves_q;
  logic [SW-1:0]      settle_q;
  logic               fire_q;
  logic [3:0]         row_column_q;
  logic               x_nrow_q;
  logic               scramble_q;
  logic               game_won_q;
  logic [COUNT_W-1:0] move_count_q;

  logic [3:0]         scramble_line_d;
  logic               player_accept_d;
  logic [COUNT_W-1:0] move_count_inc_d;

  function automatic logic [3:0] decode_line(input logic [1:0] sel);
    logic [3:0] line;
    case (sel)
      2'd0:    line = 4'b0001;
      2'd1:    line = 4'b0010;
      2'd2:    line = 4'b0100;
      2'd3:    line = 4'b1000;
      default: line = 4'b0000;
    endcase
    return line;
  endfunction

  // Scramble line decode, player move acceptance and saturating count increment
  always_comb begin
    scramble_line_d = decode_line(random_num[1:0]);
    player_accept_d = fire_pulse & ~error & ~fire_q;
    if (move_count_q == {COUNT_W{1'b1}}) begin
      move_count_inc_d = move_count_q;
    end else begin
      move_count_inc_d = move_count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sequencer FSM with all outputs registered
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_SCRAMBLE;
      gap_q        <= '0;
      moves_q      <= '0;
      settle_q     <= '0;
      fire_q       <= 1'b0;
      row_column_q <= 4'b0000;
      x_nrow_q     <= 1'b0;
      scramble_q   <= 1'b1;
      game_won_q   <= 1'b0;
      move_count_q <= '0;
    end else if (start) begin
      state_q      <= S_SCRAMBLE;
      gap_q        <= '0;
      moves_q      <= '0;
      settle_q     <= '0;
      fire_q       <= 1'b0;
      scramble_q   <= 1'b1;
      game_won_q   <= 1'b0;
      move_count_q <= '0;
    end else begin
      case (state_q)
        S_SCRAMBLE: begin
          if (moves_q == MW'(SCRAMBLE_MOVES)) begin
            state_q  <= S_SETTLE;
            settle_q <= '0;
            fire_q   <= 1'b0;
          end else if (gap_q == GW'(MOVE_GAP - 1)) begin
            gap_q        <= '0;
            moves_q      <= moves_q + 1'b1;
            fire_q       <= 1'b1;
            row_column_q <= scramble_line_d;
            x_nrow_q     <= random_num[2];
            // Leave on the last issue edge so settling counts from the final fire
            if (moves_q + 1'b1 == MW'(SCRAMBLE_MOVES)) begin
              state_q  <= S_SETTLE;
              settle_q <= '0;
            end
          end else begin
            gap_q  <= gap_q + 1'b1;
            fire_q <= 1'b0;
          end
        end
        S_SETTLE: begin
          fire_q <= 1'b0;
          if (settle_q + 1'b1 >= SW'(SETTLE_CYCLES)) begin
`ifdef GAME_SEQUENCER_REROLL_EN
            if (win) begin
              state_q <= S_SCRAMBLE;
              gap_q   <= '0;
              moves_q <= '0;
            end else begin
              state_q    <= S_PLAY;
              scramble_q <= 1'b0;
            end
`else
            state_q    <= S_PLAY;
            scramble_q <= 1'b0;
`endif
          end else begin
            settle_q <= settle_q + 1'b1;
          end
        end
        S_PLAY: begin
          row_column_q <= user_row_column;
          x_nrow_q     <= user_nRow;
          if (win) begin
            state_q    <= S_WIN;
            game_won_q <= 1'b1;
            fire_q     <= 1'b0;
          end else if (player_accept_d) begin
            fire_q       <= 1'b1;
            move_count_q <= move_count_inc_d;
          end else begin
            fire_q <= 1'b0;
          end
        end
        S_WIN: begin
          row_column_q <= user_row_column;
          x_nrow_q     <= user_nRow;
          fire_q       <= 1'b0;
        end
        default: begin
          state_q    <= S_SCRAMBLE;
          gap_q      <= '0;
          moves_q    <= '0;
          fire_q     <= 1'b0;
          scramble_q <= 1'b1;
        end
      endcase
    end
  end

  assign fire           = fire_q;
  assign row_column     = row_column_q;
  assign x_nRow         = x_nrow_q;
  assign scramble_state = scramble_q;
  assign game_won       = game_won_q;
  assign move_count     = move_count_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Randomized bench for game_sequencer: a phase/timestamp reference model checked every cycle,
// plus literal checks of scramble timing, player latency, saturation, win freeze and reset.
module tb_game_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, fire_pulse, user_nRow, error, win;
  logic [3:0]  user_row_column;
  logic [2:0]  random_num;

  logic        fire_a, x_a, scr_a, won_a;
  logic [3:0]  rc_a;
  logic [3:0]  cnt_a;
  logic        fire_b, x_b, scr_b, won_b;
  logic [3:0]  rc_b;
  logic [13:0] cnt_b;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  game_sequencer #(.SCRAMBLE_MOVES(16), .MOVE_GAP(4), .SETTLE_CYCLES(4), .COUNT_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .fire_pulse(fire_pulse),
    .user_row_column(user_row_column), .user_nRow(user_nRow), .error(error),
    .random_num(random_num), .win(win), .fire(fire_a), .row_column(rc_a),
    .x_nRow(x_a), .scramble_state(scr_a), .game_won(won_a), .move_count(cnt_a));

  game_sequencer dut_wide (
    .clk(clk), .reset(reset), .start(start), .fire_pulse(fire_pulse),
    .user_row_column(user_row_column), .user_nRow(user_nRow), .error(error),
    .random_num(random_num), .win(win), .fire(fire_b), .row_column(rc_b),
    .x_nRow(x_b), .scramble_state(scr_b), .game_won(won_b), .move_count(cnt_b));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 = grid owned by sequencer, t = edges since scramble began
  localparam int M_LAST_FIRE = 16 * 4;
  localparam int M_END       = M_LAST_FIRE + 4;
  int         m_phase, m_t, m_cnt;
  logic       m_fire, m_x, m_won;
  logic [3:0] m_rc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_phase = 0; m_t = 0; m_cnt = 0; m_fire = 1'b0; m_rc = 4'b0000; m_x = 1'b0; m_won = 1'b0;
    end else if (start) begin
      m_phase = 0; m_t = 0; m_cnt = 0; m_fire = 1'b0; m_won = 1'b0;
    end else if (m_phase == 0) begin
      m_t = m_t + 1;
      m_fire = (m_t % 4 == 0) && (m_t <= M_LAST_FIRE);
      if (m_fire) begin
        m_rc = 4'b0001 << random_num[1:0];
        m_x  = random_num[2];
      end
      if (m_t == M_END) begin
`ifdef GAME_SEQUENCER_REROLL_EN
        if (win) m_t = 0;
        else     m_phase = 2;
`else
        m_phase = 2;
`endif
      end
    end else begin
      m_rc = user_row_column;
      m_x  = user_nRow;
      if (m_phase == 3) begin
        m_fire = 1'b0;
      end else if (win) begin
        m_phase = 3; m_won = 1'b1; m_fire = 1'b0;
      end else if (fire_pulse && !error && !m_fire) begin
        m_fire = 1'b1; m_cnt = m_cnt + 1;
      end else begin
        m_fire = 1'b0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(posedge clk) begin
    #2;
    chk("fire",     {31'd0, fire_a}, {31'd0, m_fire});
    chk("rc",       {28'd0, rc_a},   {28'd0, m_rc});
    chk("x_nRow",   {31'd0, x_a},    {31'd0, m_x});
    chk("scramble", {31'd0, scr_a},  {31'd0, (m_phase == 0)});
    chk("won",      {31'd0, won_a},  {31'd0, m_won});
    chk("cnt4",     {28'd0, cnt_a},  (m_cnt > 15) ? 32'd15 : m_cnt);
    chk("fire_w",   {31'd0, fire_b}, {31'd0, m_fire});
    chk("rc_w",     {28'd0, rc_b},   {28'd0, m_rc});
    chk("cnt14",    {18'd0, cnt_b},  (m_cnt > 16383) ? 32'd16383 : m_cnt);
  end

  always @(negedge clk) random_num = 3'($urandom);

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_game();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watch a scramble batch: fire count, first fire edge, edge at which scramble_state drops
  task automatic measure(input int win_until, output int fires, output int first, output int drop);
    fires = 0; first = 0; drop = 0;
    for (int i = 1; i <= 400 && drop == 0; i++) begin
      win = (i <= win_until);
      @(negedge clk);
      if (fire_a) begin
        fires++;
        if (first == 0) first = i;
      end
      if (!scr_a) drop = i;
    end
  endtask

  task automatic pulse(input logic err);
    error = err; fire_pulse = 1'b1;
    @(negedge clk);
    fire_pulse = 1'b0;
    @(negedge clk);
  endtask

  int fires, first, drop, seen;

  initial begin
    reset = 1'b0; start = 1'b0; fire_pulse = 1'b0; user_nRow = 1'b0;
    error = 1'b0; win = 1'b0; user_row_column = 4'b0000;
    #12;
    chk("rst_fire", {31'd0, fire_a}, 32'd0);
    chk("rst_rc",   {28'd0, rc_a},   32'd0);
    chk("rst_x",    {31'd0, x_a},    32'd0);
    chk("rst_scr",  {31'd0, scr_a},  32'd1);
    chk("rst_won",  {31'd0, won_a},  32'd0);
    chk("rst_cnt",  {28'd0, cnt_a},  32'd0);
    @(negedge clk);
    reset = 1'b1;
    measure(0, fires, first, drop);
    chk("batch_fires", fires, 32'd16);
    chk("batch_first", first, 32'd4);
    chk("batch_drop",  drop,  32'd68);

    user_row_column = 4'b0100; user_nRow = 1'b0; error = 1'b0; fire_pulse = 1'b1;
    @(negedge clk);
    fire_pulse = 1'b0;
    chk("play_fire", {31'd0, fire_a}, 32'd1);
    chk("play_rc",   {28'd0, rc_a},   32'd4);
    chk("play_x",    {31'd0, x_a},    32'd0);
    chk("play_cnt",  {28'd0, cnt_a},  32'd1);
    @(negedge clk);

    seen = 0;
    for (int k = 0; k < 3; k++) begin
      error = 1'b1; fire_pulse = 1'b1;
      @(negedge clk);
      fire_pulse = 1'b0;
      if (fire_a) seen++;
      @(negedge clk);
      if (fire_a) seen++;
    end
    error = 1'b0;
    chk("err_fires", seen, 32'd0);
    chk("err_cnt",   {28'd0, cnt_a}, 32'd1);

    for (int k = 0; k < 200; k++) begin
      user_row_column = 4'($urandom);
      user_nRow       = 1'($urandom);
      error           = ($urandom % 4 == 0);
      fire_pulse      = !fire_pulse && ($urandom % 3 == 0);
      @(negedge clk);
    end
    fire_pulse = 1'b0; error = 1'b0;

    start_game();
    chk("start_cnt", {28'd0, cnt_a}, 32'd0);
    chk("start_scr", {31'd0, scr_a}, 32'd1);
    measure(0, fires, first, drop);
    chk("batch2_drop", drop, 32'd68);
    for (int k = 0; k < 20; k++) pulse(1'b0);
    chk("sat_cnt4",  {28'd0, cnt_a}, 32'd15);
    chk("sat_cnt14", {18'd0, cnt_b}, 32'd20);

    win = 1'b1; fire_pulse = 1'b1;
    @(negedge clk);
    fire_pulse = 1'b0; win = 1'b0;
    chk("win_won",  {31'd0, won_a}, 32'd1);
    chk("win_fire", {31'd0, fire_a}, 32'd0);
    chk("win_cnt",  {18'd0, cnt_b}, 32'd20);
    for (int k = 0; k < 5; k++) pulse(1'b0);
    chk("win_frozen", {18'd0, cnt_b}, 32'd20);

    start_game();
    chk("restart_won", {31'd0, won_a}, 32'd0);
    chk("restart_cnt", {18'd0, cnt_b}, 32'd0);
    measure(0, fires, first, drop);
    chk("batch3_fires", fires, 32'd16);

    start_game();
`ifdef GAME_SEQUENCER_REROLL_EN
    measure(100, fires, first, drop);
    chk("reroll_fires", fires, 32'd32);
    chk("reroll_drop",  drop,  32'd136);
`else
    measure(1000, fires, first, drop);
    chk("solved_drop", drop, 32'd68);
    chk("solved_play", {31'd0, won_a}, 32'd0);
    @(negedge clk);
    chk("solved_win", {31'd0, won_a}, 32'd1);
`endif
    win = 1'b0;

    start_game();
    seen = 0;
    for (int i = 0; i < 100 && seen < 7; i++) begin
      @(negedge clk);
      if (fire_a) seen++;
    end
    chk("mid_seen", seen, 32'd7);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_rc",  {28'd0, rc_a},  32'd0);
    chk("mid_rst_scr", {31'd0, scr_a}, 32'd1);
    chk("mid_rst_x",   {31'd0, x_a},   32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    measure(0, fires, first, drop);
    chk("fresh_fires", fires, 32'd16);
    chk("fresh_first", first, 32'd4);
    chk("fresh_drop",  drop,  32'd68);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
